// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full-adder cell adds two WIDTH-bit
// operands LSB first, one bit per clock, behind a start/busy/done handshake.

module full_adder (
    input  logic in1,
    input  logic in2,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = in1 ^ in2 ^ cin;
    assign cout = (in1 & in2) | (cin & (in1 ^ in2));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    logic [1:0]       state_r;
    logic [WIDTH-1:0] sh_a_r;
    logic [WIDTH-1:0] sh_b_r;
    logic [WIDTH-1:0] sh_s_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic             sum_s;
    logic             fa_cout_s;
    logic [WIDTH-1:0] s_next_s;

    full_adder u_fa (
        .in1  (sh_a_r[0]),
        .in2  (sh_b_r[0]),
        .cin  (carry_r),
        .sum  (sum_s),
        .cout (fa_cout_s)
    );

    // A one-bit sum register simply takes the new sum bit; wider ones shift it in at the MSB.
    generate
        if (WIDTH == 1) begin : g_w1
            assign s_next_s = sum_s;
        end else begin : g_wn
            assign s_next_s = {sum_s, sh_s_r[WIDTH-1:1]};
        end
    endgenerate

    assign busy = (state_r == RUN);
    assign done = (state_r == DONE);

    // Handshake FSM, operand/sum shifters, carry and bit counter.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= IDLE;
            sh_a_r  <= '0;
            sh_b_r  <= '0;
            sh_s_r  <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            result  <= '0;
            cout    <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r <= RUN;
                        sh_a_r  <= op_a;
                        sh_b_r  <= op_b;
                        sh_s_r  <= '0;
                        carry_r <= cin;
                        cnt_r   <= '0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    sh_a_r  <= sh_a_r >> 1'b1;
                    sh_b_r  <= sh_b_r >> 1'b1;
                    sh_s_r  <= s_next_s;
                    carry_r <= fa_cout_s;
                    cnt_r   <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        result  <= s_next_s;
                        cout    <= fa_cout_s;
                        state_r <= DONE;
                    end else begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomised checks of serial_add_ctrl at WIDTH=8 and WIDTH=1
// against plain integer addition.

module tb_serial_add_ctrl;
    logic       clk = 1'b0;
    logic       sys_rst_n;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] op_a8, op_b8, result8;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] op_a1, op_b1, result1;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .sys_clk(clk), .sys_rst_n(sys_rst_n), .start(start8),
        .op_a(op_a8), .op_b(op_b8), .cin(cin8),
        .busy(busy8), .done(done8), .result(result8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .sys_clk(clk), .sys_rst_n(sys_rst_n), .start(start1),
        .op_a(op_a1), .op_b(op_b1), .cin(cin1),
        .busy(busy1), .done(done1), .result(result1), .cout(cout1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on the 8-bit unit and wait (bounded) for it to leave RUN.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, output int nbusy);
        op_a8 = a; op_b8 = b; cin8 = c; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 40 && busy8; i++) begin
            nbusy++;
            tick();
        end
    endtask

    task automatic op1(input logic a, input logic b, input logic c, output int nbusy);
        op_a1 = a; op_b1 = b; cin1 = c; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 10 && busy1; i++) begin
            nbusy++;
            tick();
        end
    endtask

    // Outputs may only move on the edge that enters DONE (or through reset).
    logic [7:0] prev_res8;
    logic       prev_cout8;
    logic [0:0] prev_res1;
    logic       prev_cout1;
    always @(negedge clk) begin
        if (!sys_rst_n) begin
            prev_res8 = 8'h00; prev_cout8 = 1'b0;
            prev_res1 = 1'b0;  prev_cout1 = 1'b0;
        end else begin
            if (!done8) chk("stable8", {result8, cout8}, {prev_res8, prev_cout8});
            if (!done1) chk("stable1", {result1, cout1}, {prev_res1, prev_cout1});
            prev_res8 = result8; prev_cout8 = cout8;
            prev_res1 = result1; prev_cout1 = cout1;
        end
    end

    initial begin
        int nb, gap, ndone;
        logic [8:0] exp9;
        logic [1:0] exp2;
        logic [7:0] ra, rb;
        logic       rc;

        sys_rst_n = 1'b0;
        start8 = 1'b0; op_a8 = 8'h00; op_b8 = 8'h00; cin8 = 1'b0;
        start1 = 1'b0; op_a1 = 1'b0;  op_b1 = 1'b0;  cin1 = 1'b0;
        tick(); tick();
        chk("rst_outs8", {busy8, done8, result8, cout8}, 64'h0);
        chk("rst_outs1", {busy1, done1, result1, cout1}, 64'h0);
        sys_rst_n = 1'b1;
        tick();
        chk("idle8", {busy8, done8}, 64'h0);

        // Basic add with latency check
        op8(8'h3C, 8'h5A, 1'b0, nb);
        chk("lat_busy", nb, 8);
        chk("lat_done", done8, 1'b1);
        chk("add_3c5a", {cout8, result8}, 9'h096);
        tick();
        chk("done_1cyc", done8, 1'b0);

        op8(8'hFF, 8'h01, 1'b0, nb);
        chk("ff01", {done8, cout8, result8}, {1'b1, 9'h100});
        tick();
        op8(8'hFF, 8'hFF, 1'b1, nb);
        chk("ffff1", {done8, cout8, result8}, {1'b1, 9'h1FF});
        tick();

        // start held high: back-to-back ops, operands changed after capture
        op_a8 = 8'h01; op_b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
        tick();
        op_a8 = 8'h80; op_b8 = 8'h80; cin8 = 1'b1;
        gap = 0;
        for (int i = 0; i < 40 && !done8; i++) begin gap++; tick(); end
        chk("b2b_first", {done8, cout8, result8}, {1'b1, 9'h003});
        tick();
        chk("b2b_no_idle", busy8, 1'b1);
        gap = 1;
        for (int i = 0; i < 40 && !done8; i++) begin gap++; tick(); end
        chk("b2b_spacing", gap, 9);
        chk("b2b_second", {done8, cout8, result8}, {1'b1, 9'h101});
        start8 = 1'b0;
        tick();
        chk("b2b_to_idle", {busy8, done8}, 64'h0);

        // start pulsed mid-RUN is ignored; in-flight op continues
        op_a8 = 8'h0F; op_b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        op_a8 = 8'h10; op_b8 = 8'h10; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (done8) begin
                ndone++;
                chk("ign_result", {cout8, result8}, 9'h010);
            end
            tick();
        end
        chk("ign_one_done", ndone, 1);

        // Asynchronous reset mid-RUN
        op_a8 = 8'h55; op_b8 = 8'h66; cin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick();
        sys_rst_n = 1'b0;
        #1;
        chk("async_rst", {busy8, done8, result8, cout8}, 64'h0);
        tick();
        sys_rst_n = 1'b1;
        tick();
        op8(8'h7F, 8'h01, 1'b0, nb);
        chk("post_rst", {done8, cout8, result8}, {1'b1, 9'h080});
        tick();

        // Randomised WIDTH=8
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            exp9 = 9'(ra) + 9'(rb) + 9'(rc);
            op8(ra, rb, rc, nb);
            chk("rand8_busy", nb, 8);
            chk("rand8_sum", {done8, cout8, result8}, {1'b1, exp9});
            if ($urandom_range(0, 1) == 0) tick();
        end
        tick();

        // Randomised WIDTH=1
        for (int n = 0; n < 200; n++) begin
            ra = 8'($urandom_range(0, 1)); rb = 8'($urandom_range(0, 1)); rc = 1'($urandom);
            exp2 = 2'(ra[0]) + 2'(rb[0]) + 2'(rc);
            op1(ra[0], rb[0], rc, nb);
            chk("rand1_busy", nb, 1);
            chk("rand1_sum", {done1, cout1, result1}, {1'b1, exp2});
            if ($urandom_range(0, 1) == 0) tick();
        end
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
